// File: rtl/y86_fetch_stage_p.sv
// Y86-64 fetch stage: PC select, byte-addressed imem with write port, predecoder, F and F/D registers.
// Optional return-address stack enabled by defining FETCH_RAS_EN.
module y86_fetch_stage_p #(
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter logic [63:0] RESET_PC   = '0,
    parameter bit          IMM_LE     = 1'b0,
    parameter int unsigned RAS_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [7:0]                    imem_wdata,
    input  logic                          F_stall,
    input  logic                          D_stall,
    input  logic                          D_bubble,
    input  logic [3:0]                    M_icode,
    input  logic                          M_cnd,
    input  logic [63:0]                   M_valA,
    input  logic [3:0]                    W_icode,
    input  logic [63:0]                   W_valM,
    output logic [63:0]                   f_pc,
    output logic [63:0]                   F_predPC,
    output logic [3:0]                    D_stat,
    output logic [3:0]                    D_icode,
    output logic [3:0]                    D_ifun,
    output logic [3:0]                    D_rA,
    output logic [3:0]                    D_rB,
    output logic [63:0]                   D_valC,
    output logic [63:0]                   D_valP
);
    localparam int unsigned AW      = $clog2(IMEM_DEPTH);
    localparam logic [64:0] DEPTH65 = 65'(IMEM_DEPTH);

    typedef enum logic [3:0] {
        I_HALT = 4'h0, I_NOP = 4'h1, I_RRMOV = 4'h2, I_IRMOV = 4'h3,
        I_RMMOV = 4'h4, I_MRMOV = 4'h5, I_OP = 4'h6, I_JXX = 4'h7,
        I_CALL = 4'h8, I_RET = 4'h9, I_PUSH = 4'hA, I_POP = 4'hB
    } icode_e;

    typedef enum logic [3:0] {
        S_AOK = 4'b1000, S_HLT = 4'b0100, S_ADR = 4'b0010, S_INS = 4'b0001
    } stat_e;

    logic [7:0]  imem [IMEM_DEPTH];
    logic [7:0]  fb   [10];
    logic [64:0] baddr, last_byte;
    logic [7:0]  cbyte;
    icode_e      f_icode;
    logic [3:0]  f_ifun, f_rA, f_rB, f_len;
    logic        need_regs, has_valc, valc_at2, f_valid;
    stat_e       f_stat;
    logic [63:0] f_valC, f_valP, f_predPC;
    logic        ras_hit;
    logic [63:0] ras_top;

    always_ff @(posedge clk) begin
        if (imem_we) imem[imem_waddr] <= imem_wdata;
    end

    always_comb begin
        f_pc = F_predPC;
        if (W_icode == I_RET)                f_pc = W_valM;
        else if (M_icode == I_JXX && !M_cnd) f_pc = M_valA;
    end

    // Bytes past the end of memory (or past a 64-bit wrap) read as zero.
    always_comb begin
        baddr = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            baddr = {1'b0, f_pc} + 65'(i);
            fb[i] = (baddr < DEPTH65) ? imem[baddr[AW-1:0]] : '0;
        end
    end

    always_comb begin
        f_icode   = icode_e'(fb[0][7:4]);
        f_ifun    = fb[0][3:0];
        f_len     = 4'd1;
        need_regs = 1'b0;
        has_valc  = 1'b0;
        valc_at2  = 1'b0;
        f_valid   = 1'b1;
        case (f_icode)
            I_HALT, I_NOP, I_RET: f_len = 4'd1;
            I_RRMOV, I_OP, I_PUSH, I_POP: begin
                f_len     = 4'd2;
                need_regs = 1'b1;
            end
            I_IRMOV, I_RMMOV, I_MRMOV: begin
                f_len     = 4'd10;
                need_regs = 1'b1;
                has_valc  = 1'b1;
                valc_at2  = 1'b1;
            end
            I_JXX, I_CALL: begin
                f_len    = 4'd9;
                has_valc = 1'b1;
            end
            default: f_valid = 1'b0;
        endcase

        f_rA = need_regs ? fb[1][7:4] : 4'hF;
        f_rB = need_regs ? fb[1][3:0] : 4'hF;

        f_valC = '0;
        cbyte  = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            cbyte = valc_at2 ? fb[k+2] : fb[k+1];
            if (!has_valc) cbyte = '0;
            if (IMM_LE) f_valC[8*k +: 8]    = cbyte;
            else        f_valC[56-8*k +: 8] = cbyte;
        end

        f_valP    = f_pc + 64'(f_len);
        last_byte = {1'b0, f_pc} + 65'(f_len) - 65'd1;

        if (last_byte >= DEPTH65)  f_stat = S_ADR;
        else if (!f_valid)         f_stat = S_INS;
        else if (f_icode == I_HALT) f_stat = S_HLT;
        else                       f_stat = S_AOK;

        if (f_stat != S_AOK)                          f_predPC = f_pc;
        else if (f_icode == I_JXX || f_icode == I_CALL) f_predPC = f_valC;
        else if (f_icode == I_RET && ras_hit)         f_predPC = ras_top;
        else                                          f_predPC = f_valP;
    end

`ifdef FETCH_RAS_EN
    localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [63:0] ras [RAS_DEPTH];
    logic [PW-1:0] ras_wp, ras_top_idx;
    logic [PW:0]   ras_cnt;
    logic          ras_push, ras_pop;

    // ras_wp is the next slot to write; a full stack wraps over its oldest entry.
    always_comb begin
        ras_top_idx = (ras_wp == '0) ? PW'(RAS_DEPTH - 1) : ras_wp - 1'b1;
        ras_hit     = (ras_cnt != '0);
        ras_top     = ras[ras_top_idx];
        ras_push    = !D_stall && !D_bubble && f_icode == I_CALL;
        ras_pop     = !D_stall && !D_bubble && f_icode == I_RET && ras_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_wp  <= '0;
            ras_cnt <= '0;
        end else if (ras_push) begin
            ras_wp  <= (ras_wp == PW'(RAS_DEPTH - 1)) ? '0 : ras_wp + 1'b1;
            if (ras_cnt != (PW+1)'(RAS_DEPTH)) ras_cnt <= ras_cnt + 1'b1;
        end else if (ras_pop) begin
            ras_wp  <= ras_top_idx;
            ras_cnt <= ras_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ras_push) ras[ras_wp] <= f_valP;
    end
`else
    assign ras_hit = 1'b0;
    assign ras_top = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           F_predPC <= RESET_PC;
        else if (!F_stall) F_predPC <= f_predPC;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || (!D_stall && D_bubble)) begin
            D_stat  <= S_AOK;
            D_icode <= I_NOP;
            D_ifun  <= '0;
            D_rA    <= 4'hF;
            D_rB    <= 4'hF;
            D_valC  <= '0;
            D_valP  <= '0;
        end else if (!D_stall) begin
            D_stat  <= f_stat;
            D_icode <= f_icode;
            D_ifun  <= f_ifun;
            D_rA    <= f_rA;
            D_rB    <= f_rB;
            D_valC  <= f_valC;
            D_valP  <= f_valP;
        end
    end
endmodule

// File: tb/tb_y86_fetch_stage_p.sv
// Scoreboard bench for y86_fetch_stage_p: directed scenarios plus randomized control/redirect traffic.
module tb_y86_fetch_stage_p;
    localparam int unsigned DEPTH = 512;
    localparam logic [63:0] RPC   = 64'h0;
    localparam bit          LE    = 1'b0;
    localparam int unsigned RD    = 4;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          imem_we = 1'b0;
    logic [AW-1:0] imem_waddr = '0;
    logic [7:0]    imem_wdata = '0;
    logic          F_stall = 1'b0, D_stall = 1'b0, D_bubble = 1'b0;
    logic [3:0]    M_icode = '0, W_icode = '0;
    logic          M_cnd = 1'b0;
    logic [63:0]   M_valA = '0, W_valM = '0;
    logic [63:0]   f_pc, F_predPC, D_valC, D_valP;
    logic [3:0]    D_stat, D_icode, D_ifun, D_rA, D_rB;

    y86_fetch_stage_p #(.IMEM_DEPTH(DEPTH), .RESET_PC(RPC), .IMM_LE(LE), .RAS_DEPTH(RD)) dut (
        .clk(clk), .rst(rst), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .M_icode(M_icode), .M_cnd(M_cnd), .M_valA(M_valA), .W_icode(W_icode), .W_valM(W_valM),
        .f_pc(f_pc), .F_predPC(F_predPC), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
        .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  stat, icode, ifun, ra, rb;
        logic [63:0] valc, valp, pred;
    } fetch_t;

    typedef struct {
        logic [63:0] fpc, pre_pred, pred;
        logic [3:0]  pre_icode;
        fetch_t      d;
    } item_t;

    logic [7:0]  prog [DEPTH];
    logic [7:0]  mm   [DEPTH];
    logic [63:0] stk  [$];
    item_t       q    [$];
    logic [63:0] m_pred;
    fetch_t      m_d;
    int          checks = 0;
    int          failures = 0;

    function automatic fetch_t bubble();
        fetch_t b;
        b = '{stat: 4'b1000, icode: 4'h1, ifun: 4'h0, ra: 4'hF, rb: 4'hF, valc: 64'h0, valp: 64'h0, pred: 64'h0};
        return b;
    endfunction

    function automatic logic [7:0] mbyte(input logic [63:0] pc, input int unsigned k);
        if (pc >= 64'(DEPTH)) return 8'h00;
        if (64'(k) > 64'(DEPTH - 1) - pc) return 8'h00;
        return mm[32'(pc) + k];
    endfunction

    function automatic int unsigned ilen(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       return 1;
            4'h2, 4'h6, 4'hA, 4'hB: return 2;
            4'h3, 4'h4, 4'h5:       return 10;
            4'h7, 4'h8:             return 9;
            default:                return 0;
        endcase
    endfunction

    function automatic fetch_t do_fetch(input logic [63:0] pc);
        fetch_t      f;
        logic [7:0]  b0, b1, b;
        int unsigned len, start;
        logic        ins, adr;
        b0 = mbyte(pc, 0);
        b1 = mbyte(pc, 1);
        f.icode = b0[7:4];
        f.ifun  = b0[3:0];
        len = ilen(f.icode);
        ins = (len == 0);
        if (ins) len = 1;
        adr = (pc >= 64'(DEPTH)) || (64'(len) > 64'(DEPTH) - pc);
        if (!ins && len >= 2 && f.icode != 4'h7 && f.icode != 4'h8) begin
            f.ra = b1[7:4];
            f.rb = b1[3:0];
        end else begin
            f.ra = 4'hF;
            f.rb = 4'hF;
        end
        f.valc = 64'h0;
        start = (len == 10) ? 2 : 1;
        if (len >= 9) begin
            for (int unsigned j = 0; j < 8; j++) begin
                b = mbyte(pc, start + j);
                if (LE) f.valc = f.valc | (64'(b) << (8 * j));
                else    f.valc = (f.valc << 8) | 64'(b);
            end
        end
        f.valp = pc + 64'(len);
        f.stat = adr ? 4'b0010 : ins ? 4'b0001 : (f.icode == 4'h0) ? 4'b0100 : 4'b1000;
        if (f.stat != 4'b1000)                      f.pred = pc;
        else if (f.icode == 4'h7 || f.icode == 4'h8) f.pred = f.valc;
`ifdef FETCH_RAS_EN
        else if (f.icode == 4'h9 && stk.size() > 0) f.pred = stk[$];
`endif
        else                                         f.pred = f.valp;
        return f;
    endfunction

    // Compute the expected response for the inputs currently driven, queue it, advance one cycle.
    task automatic tick();
        item_t       it;
        fetch_t      f;
        logic [63:0] fpc;
        if (rst) begin
            m_pred = RPC;
            m_d    = bubble();
            stk.delete();
        end
        if (W_icode == 4'h9)                fpc = W_valM;
        else if (M_icode == 4'h7 && !M_cnd) fpc = M_valA;
        else                                fpc = m_pred;
        it.fpc       = fpc;
        it.pre_pred  = m_pred;
        it.pre_icode = m_d.icode;
        f = do_fetch(fpc);
        if (!rst) begin
            if (!F_stall) m_pred = f.pred;
            if (!D_stall) begin
                if (D_bubble) m_d = bubble();
                else begin
                    m_d = f;
`ifdef FETCH_RAS_EN
                    if (f.icode == 4'h8) begin
                        stk.push_back(f.valp);
                        if (stk.size() > RD) void'(stk.pop_front());
                    end else if (f.icode == 4'h9 && stk.size() > 0) begin
                        void'(stk.pop_back());
                    end
`endif
                end
            end
        end
        if (imem_we) mm[imem_waddr] = imem_wdata;
        it.pred = m_pred;
        it.d    = m_d;
        q.push_back(it);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        imem_we = 1'b0; F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
        M_icode = 4'h0; M_cnd = 1'b1; M_valA = '0; W_icode = 4'h0; W_valM = '0;
    endtask

    task automatic redirect(input logic [63:0] pc);
        idle();
        W_icode = 4'h9;
        W_valM  = pc;
        tick();
        idle();
    endtask

    task automatic put(input int unsigned a, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [7:0] regs, input logic [63:0] valc);
        int unsigned len, off;
        len = ilen(ic);
        if (a < DEPTH) prog[a] = {ic, fn};
        if (len == 2 || len == 10) begin
            if (a + 1 < DEPTH) prog[a+1] = regs;
        end
        off = (len == 10) ? 2 : 1;
        if (len >= 9) begin
            for (int unsigned j = 0; j < 8; j++) begin
                if (a + off + j < DEPTH)
                    prog[a+off+j] = LE ? valc[8*j +: 8] : valc[56-8*j +: 8];
            end
        end
    endtask

    always begin
        item_t it;
        @(negedge clk);
        #2;
        if (q.size() > 0) begin
            it = q.pop_front();
            chk("f_pc", f_pc, it.fpc);
            chk("F_predPC_pre", F_predPC, it.pre_pred);
            chk("D_icode_pre", 64'(D_icode), 64'(it.pre_icode));
            @(posedge clk);
            #1;
            chk("F_predPC", F_predPC, it.pred);
            chk("D_stat", 64'(D_stat), 64'(it.d.stat));
            chk("D_icode", 64'(D_icode), 64'(it.d.icode));
            chk("D_ifun", 64'(D_ifun), 64'(it.d.ifun));
            chk("D_rA", 64'(D_rA), 64'(it.d.ra));
            chk("D_rB", 64'(D_rB), 64'(it.d.rb));
            chk("D_valC", D_valC, it.d.valc);
            chk("D_valP", D_valP, it.d.valp);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned a;
        logic [3:0]  ic;
        m_pred = RPC;
        m_d    = bubble();
        a = 0;
        while (a < DEPTH) begin
            ic = 4'($urandom_range(0, 15));
            put(a, ic, (ic == 4'h2 || ic == 4'h7) ? 4'($urandom_range(0, 6)) : 4'h0,
                8'($urandom), (ic == 4'h7 || ic == 4'h8) ? 64'($urandom_range(0, DEPTH - 1)) : {$urandom, $urandom});
            a += (ilen(ic) == 0) ? 1 : ilen(ic);
        end
        put(0, 4'h3, 4'h0, 8'hF2, 64'd10);
        put(10, 4'h7, 4'h4, 8'h00, 64'h40);
        put(32'h20, 4'h0, 4'h0, 8'h00, 64'h0);
        prog[32'h30] = 8'hC0;
        put(DEPTH - 5, 4'h3, 4'h0, 8'hF2, 64'h1234);
        prog[32'h60] = 8'h00;
        put(32'h80, 4'h8, 4'h0, 8'h00, 64'h100);
        put(32'h100, 4'h9, 4'h0, 8'h00, 64'h0);
        for (int unsigned k = 0; k <= RD; k++)
            put(32'h140 + 9 * k, 4'h8, 4'h0, 8'h00, 64'(32'h140 + 9 * (k + 1)));
        for (int unsigned k = 0; k <= RD + 1; k++)
            prog[32'h140 + 9 * (RD + 1) + k] = 8'h90;

        @(negedge clk);
        idle();
        rst = 1'b1;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            imem_we    = 1'b1;
            imem_waddr = AW'(i);
            imem_wdata = prog[i];
            tick();
        end
        idle();
        rst = 1'b0;
        tick();
        tick();
        M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h2B; D_bubble = 1'b1;
        tick();
        idle();
        tick();
        tick();

        F_stall = 1'b1; D_stall = 1'b1;
        repeat (3) tick();
        idle();
        repeat (2) tick();

        redirect(64'(DEPTH - 5));
        repeat (2) tick();
        redirect(64'h30);
        repeat (2) tick();
        redirect(64'h20);
        repeat (3) tick();
        redirect(64'hFFFF_FFFF_FFFF_FFFC);
        redirect(64'h0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        W_icode = 4'h9; W_valM = 64'h60; imem_we = 1'b1; imem_waddr = AW'(32'h60); imem_wdata = 8'h10;
        tick();
        redirect(64'h60);

        redirect(64'h80);
        repeat (2) tick();
        redirect(64'h140);
        repeat (2 * (RD + 1) + 6) tick();

        repeat (2000) begin
            idle();
            F_stall  = ($urandom_range(0, 7) == 0);
            D_stall  = ($urandom_range(0, 7) == 0);
            D_bubble = ($urandom_range(0, 7) == 0);
            M_icode  = 4'($urandom_range(0, 15));
            M_cnd    = 1'($urandom);
            M_valA   = ($urandom_range(0, 15) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, DEPTH + 15));
            W_icode  = ($urandom_range(0, 15) == 0) ? 4'h9 : 4'($urandom_range(0, 8));
            W_valM   = 64'($urandom_range(0, DEPTH + 15));
            if ($urandom_range(0, 31) == 0) begin
                imem_we    = 1'b1;
                imem_waddr = AW'($urandom);
                imem_wdata = 8'($urandom);
            end
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
            tick();
            rst = 1'b0;
        end
        idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
